multi_cycle_control: RTL

Multi-cycle control unit for the MIPS datapath. A state machine sequences each instruction through fetch, decode, execute, memory and writeback, and drives the same control wires the datapath already consumes. Instruction and data memory accesses use a req/ack handshake, so memories with arbitrary wait states are supported. Illegal instructions and memory timeouts trap, and the block counts retired instructions.

---
 rtl/multi_cycle_control_pkg.sv | 57 +++++
 rtl/instr_decode.sv | 34 +++
 rtl/multi_cycle_control.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds FSM state and instruction-kind enums, trap cause codes, opcode and
// funct values, and the mux/ALU/extender/next-PC codes shared with the
// single-cycle control path.
package multi_cycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_LUI, K_ORI, K_LW, K_SW, K_BEQ, K_NOP, K_J, K_JAL, K_UNKNOWN
  } kind_e;

  localparam logic [1:0] TRAP_NONE       = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL    = 2'd1;
  localparam logic [1:0] TRAP_IM_TIMEOUT = 2'd2;
  localparam logic [1:0] TRAP_DM_TIMEOUT = 2'd3;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;

  localparam logic [1:0] CM_RF_WRITE_ADDR_RT  = 2'd0;
  localparam logic [1:0] CM_RF_WRITE_ADDR_RD  = 2'd1;
  localparam logic [1:0] CM_RF_WRITE_ADDR_31  = 2'd2;
  localparam logic [1:0] CM_RF_WRITE_DATA_ALU = 2'd0;
  localparam logic [1:0] CM_RF_WRITE_DATA_DM  = 2'd1;
  localparam logic [1:0] CM_RF_WRITE_DATA_PC4 = 2'd2;
  localparam logic       CM_ALU_NUM2_RT       = 1'b0;
  localparam logic       CM_ALU_NUM2_EXT      = 1'b1;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;

  localparam logic [2:0] EXT_ZERO = 3'd0;
  localparam logic [2:0] EXT_SIGN = 3'd1;
  localparam logic [2:0] EXT_LUI  = 3'd2;

  localparam logic [2:0] NPC_PC4             = 3'd0;
  localparam logic [2:0] NPC_JUMP_WHEN_EQUAL = 3'd1;
  localparam logic [2:0] NPC_JUMP_ABS        = 3'd2;

  // j/jal are only legal when the jump decoder is built in.
  function automatic logic is_illegal(input kind_e k, input logic jal_en);
    return (k == K_UNKNOWN) || (!jal_en && ((k == K_J) || (k == K_JAL)));
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier shared with the single-cycle control.
// Ports: ir (32-bit instruction register) -> kind (instruction class).
// An all-zero word is the canonical nop; any other sll-style encoding or
// unrecognised opcode/funct is classified as unknown.
module instr_decode
  import multi_cycle_control_pkg::*;
(
  input  logic [31:0] ir,
  output kind_e       kind
);

  always_comb begin
    kind = K_UNKNOWN;
    if (ir == 32'h0000_0000) begin
      kind = K_NOP;
    end else begin
      case (ir[31:26])
        OP_RTYPE: begin
          if (ir[5:0] == FUNCT_ADDU)      kind = K_ADDU;
          else if (ir[5:0] == FUNCT_SUBU) kind = K_SUBU;
        end
        OP_J:    kind = K_J;
        OP_JAL:  kind = K_JAL;
        OP_BEQ:  kind = K_BEQ;
        OP_ORI:  kind = K_ORI;
        OP_LUI:  kind = K_LUI;
        OP_LW:   kind = K_LW;
        OP_SW:   kind = K_SW;
        default: kind = K_UNKNOWN;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ack memory handshakes, traps on illegal instructions and memory
// timeouts, and counts retired instructions.
// Ports:
//   clk, reset (sync, active-high)
//   instr, im_ack, dm_ack         : memory inputs
//   im_req, dm_req                : memory requests
//   cw_* / cm_*                   : datapath control wires
//   trap, trap_cause              : sticky error flag and its cause
//   retired                       : retired-instruction counter (wraps)
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int ENABLE_JAL  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             im_ack,
  input  logic             dm_ack,
  output logic             im_req,
  output logic             dm_req,
  output logic             cw_ir_write,
  output logic             cw_pc_enable,
  output logic [1:0]       cm_rf_write_addr,
  output logic [1:0]       cm_rf_write_data,
  output logic             cm_alu_num2,
  output logic [2:0]       cw_npc_jump_mode,
  output logic             cw_rf_write_enable,
  output logic [4:0]       cw_alu_op,
  output logic [2:0]       cw_ext_mode,
  output logic             cw_dm_write_enable,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;

  state_e            state;
  kind_e             kind;
  logic [31:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              timeout_hit;
  logic              illegal;

  instr_decode u_decode (
    .ir   (ir),
    .kind (kind)
  );

  assign illegal     = is_illegal(kind, ENABLE_JAL != 0);
  assign wait_next   = wait_cnt + WAIT_W'(1);
  // The ack path is checked before this, so an ack in the limit cycle wins.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_next == WAIT_W'(MEM_TIMEOUT));

  // Strobes are gated by reset so an aborted instruction writes nothing.
  always_comb begin
    im_req             = !reset && (state == S_FETCH);
    dm_req             = !reset && (state == S_MEM);
    cw_ir_write        = im_req && im_ack;
    cw_dm_write_enable = dm_req && (kind == K_SW);
    cw_rf_write_enable = !reset && (state == S_WB);
    cw_pc_enable       = !reset &&
                         (((state == S_EXEC) && ((kind == K_BEQ) || (kind == K_NOP) || (kind == K_J))) ||
                          ((state == S_MEM) && (kind == K_SW) && dm_ack) ||
                          (state == S_WB));
  end

  // Mux selects and modes follow the IR kind; they only matter DECODE..WB.
  always_comb begin
    cm_rf_write_addr = CM_RF_WRITE_ADDR_RT;
    cm_rf_write_data = CM_RF_WRITE_DATA_ALU;
    cm_alu_num2      = CM_ALU_NUM2_RT;
    cw_npc_jump_mode = NPC_PC4;
    cw_alu_op        = ALU_ADD;
    cw_ext_mode      = EXT_ZERO;
    case (kind)
      K_ADDU: cm_rf_write_addr = CM_RF_WRITE_ADDR_RD;
      K_SUBU: begin
        cm_rf_write_addr = CM_RF_WRITE_ADDR_RD;
        cw_alu_op        = ALU_SUB;
      end
      K_LUI: begin
        cm_alu_num2 = CM_ALU_NUM2_EXT;
        cw_ext_mode = EXT_LUI;
      end
      K_ORI: begin
        cm_alu_num2 = CM_ALU_NUM2_EXT;
        cw_alu_op   = ALU_OR;
      end
      K_LW: begin
        cm_rf_write_data = CM_RF_WRITE_DATA_DM;
        cm_alu_num2      = CM_ALU_NUM2_EXT;
        cw_ext_mode      = EXT_SIGN;
      end
      K_SW: begin
        cm_alu_num2 = CM_ALU_NUM2_EXT;
        cw_ext_mode = EXT_SIGN;
      end
      K_BEQ: begin
        cw_npc_jump_mode = NPC_JUMP_WHEN_EQUAL;
        cw_alu_op        = ALU_SUB;
        cw_ext_mode      = EXT_SIGN;
      end
      K_J:   cw_npc_jump_mode = NPC_JUMP_ABS;
      K_JAL: begin
        cw_npc_jump_mode = NPC_JUMP_ABS;
        cm_rf_write_addr = CM_RF_WRITE_ADDR_31;
        cm_rf_write_data = CM_RF_WRITE_DATA_PC4;
      end
      default: ;
    endcase
  end

  // IR is a plain data register: captured only on an accepted fetch.
  always_ff @(posedge clk) begin
    if (cw_ir_write) ir <= instr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      retired    <= '0;
      trap       <= 1'b0;
      trap_cause <= TRAP_NONE;
    end else begin
      if (cw_pc_enable) retired <= retired + CNT_W'(1);
      case (state)
        S_FETCH: begin
          if (im_ack) begin
            state    <= S_DECODE;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= TRAP_IM_TIMEOUT;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= TRAP_ILLEGAL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (kind)
            K_BEQ, K_NOP, K_J: state <= S_FETCH;
            K_LW, K_SW:        state <= S_MEM;
            default:           state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dm_ack) begin
            state    <= (kind == K_LW) ? S_WB : S_FETCH;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= TRAP_DM_TIMEOUT;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
